sa_cache_data: RTL and testbench
================================

SA_CACHE_DATA -- requirements
Module: sa_cache_data

Interface
REQ-001 SHALL have parameter NUM_SETS, 64, number of sets (power of 2, >=2).
REQ-002 SHALL have parameter NUM_WAYS, 4, ways per set (power of 2, 2..8).
REQ-003 SHALL have parameter DATA_W, 128, line width in bits (multiple of 8).
REQ-004 SHALL have parameter LRU_W, 3, replacement-state width per set, opaque to this block.
REQ-005 SHALL have ports (IW=log2 NUM_SETS, WW=log2 NUM_WAYS):
  clk  in  1  clock, all state on rising edge.
  rst_n  in  1  reset; asynchronous, active-low.
  req_valid  in  1  request present.
  req_ready  out  1  request accepted when req_valid && req_ready.
  req_index  in  IW  set index.
  req_way  in  WW  way select.
  req_we  in  1  write line.
  req_inv  in  1  invalidate line (ignored if req_we=1).
  req_be  in  DATA_W/8  byte enables for write.
  req_wdata  in  DATA_W  write data.
  lru_we  in  1  update set replacement state.
  lru_next  in  LRU_W  new replacement state.
  rd_valid  out  1  read result valid.
  rd_data  out  DATA_W  addressed line, pre-write.
  rd_line_valid  out  1  addressed line valid bit, pre-update.
  rd_lru  out  LRU_W  addressed set replacement state, pre-update.
  flush_req  in  1  start invalidate-all sweep.
  flush_busy  out  1  sweep in progress.
  flush_done  out  1  one-cycle pulse on sweep completion.

Function
REQ-006 SHALL hold per set: NUM_WAYS data lines, NUM_WAYS valid bits, one LRU_W replacement word.
REQ-007 SHALL implement states IDLE and FLUSH; req_ready = (state==IDLE) && !flush_req, combinational.
REQ-008 On accepted request SHALL, at next rising edge, assert rd_valid for exactly one cycle with rd_data, rd_line_valid, rd_lru from the addressed set/way as held before this request's updates (read-before-write, latency 1).
REQ-009 rd_data, rd_line_valid, rd_lru SHALL hold their last value while rd_valid=0.
REQ-010 Accepted request with req_we=1 SHALL write only bytes whose req_be bit is 1 and set that line's valid bit (even if req_be=0).
REQ-011 Accepted request with req_we=0, req_inv=1 SHALL clear that line's valid bit; data unchanged.
REQ-012 Accepted request with lru_we=1 SHALL write lru_next to the set's replacement word; lru_we ignored when not accepted.
REQ-013 Back-to-back accepted requests to same index/way SHALL see the previous request's write (each result reflects all earlier accepted requests).
REQ-014 flush_req=1 in IDLE SHALL enter FLUSH next edge with sweep counter 0; any concurrent req_valid is not accepted.
REQ-015 In FLUSH SHALL, each cycle, clear all valid bits and the replacement word of set[counter], then increment counter; data lines untouched.
REQ-016 After clearing set NUM_SETS-1 SHALL return to IDLE and pulse flush_done in the first IDLE cycle; sweep takes exactly NUM_SETS cycles.
REQ-017 flush_busy SHALL equal (state==FLUSH); flush_req while busy SHALL be ignored (no restart, no queueing).
REQ-018 req_index/req_way out of range cannot occur (power-of-2 sizing); no wrap logic required.

Reset
REQ-019 rst_n=0 SHALL immediately, independent of clk: state=IDLE, counter=0, rd_valid=0, rd_data=0, rd_line_valid=0, rd_lru=0, flush_done=0, all valid bits=0, all replacement words=0.
REQ-020 Data line contents SHALL be unaffected by reset.
REQ-021 Reset asserted mid-sweep SHALL abort the sweep with no flush_done pulse.

Verification
REQ-022 Write index 21, way 3, be all-1, data all-1; then read same -> rd_valid one cycle later, rd_data all-1, rd_line_valid=1.
REQ-023 Write index 5, way 0, data 0, then write be=0x0001 data 0xAB -> subsequent read returns 0x...00AB, upper bytes 0.
REQ-024 Request with lru_we=1, lru_next=3'b101 at index 7 -> that cycle's rd_lru=000; next read of index 7 rd_lru=101.
REQ-025 flush_req with req_valid=1 same cycle -> req_ready=0, flush_busy high for 64 cycles, flush_done pulse on cycle 65, all reads then rd_line_valid=0, rd_lru=0, rd_data unchanged.
REQ-026 rst_n low at sweep cycle 10 -> flush_busy, rd_valid drop without clock edge; no flush_done; all valid bits 0 after release.

Source files
------------

// File: rtl/sa_cache_data_if.sv
// Request, read-result and flush signals of the set-associative cache data array.
// The master drives requests and flush commands; the slave is the array itself.
interface sa_cache_data_if #(
  parameter int NUM_SETS = 64,
  parameter int NUM_WAYS = 4,
  parameter int DATA_W   = 128,
  parameter int LRU_W    = 3
);
  localparam int IW   = $clog2(NUM_SETS);
  localparam int WW   = $clog2(NUM_WAYS);
  localparam int BE_W = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic [IW-1:0]     req_index;
  logic [WW-1:0]     req_way;
  logic              req_we;
  logic              req_inv;
  logic [BE_W-1:0]   req_be;
  logic [DATA_W-1:0] req_wdata;
  logic              lru_we;
  logic [LRU_W-1:0]  lru_next;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_line_valid;
  logic [LRU_W-1:0]  rd_lru;
  logic              flush_req;
  logic              flush_busy;
  logic              flush_done;

  modport master (
    output req_valid, req_index, req_way, req_we, req_inv, req_be, req_wdata,
    output lru_we, lru_next, flush_req,
    input  req_ready, rd_valid, rd_data, rd_line_valid, rd_lru, flush_busy, flush_done
  );

  modport slave (
    input  req_valid, req_index, req_way, req_we, req_inv, req_be, req_wdata,
    input  lru_we, lru_next, flush_req,
    output req_ready, rd_valid, rd_data, rd_line_valid, rd_lru, flush_busy, flush_done
  );
endinterface

// File: rtl/sa_cache_data.sv
// Set-associative cache data array: per-set lines, valid bits and replacement word,
// read-before-write access with latency 1 and a one-set-per-cycle invalidate sweep.
module sa_cache_data #(
  parameter int NUM_SETS = 64,
  parameter int NUM_WAYS = 4,
  parameter int DATA_W   = 128,
  parameter int LRU_W    = 3
) (
  input logic           clk,
  input logic           rst_n,
  sa_cache_data_if.slave cache
);
  localparam int IW   = $clog2(NUM_SETS);
  localparam int BE_W = DATA_W / 8;
  localparam logic [IW-1:0] LAST_SET = IW'(NUM_SETS - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e                             state_q, state_d;
  logic [IW-1:0]                      cnt_q, cnt_d;
  logic                               flush_done_q, flush_done_d;
  logic                               rd_valid_q;
  logic [DATA_W-1:0]                  rd_data_q;
  logic                               rd_line_valid_q;
  logic [LRU_W-1:0]                   rd_lru_q;
  logic [DATA_W-1:0]                  data_q [NUM_SETS][NUM_WAYS];
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]  valid_q;
  logic [NUM_SETS-1:0][LRU_W-1:0]     lru_q;
  logic                               ready_s;
  logic                               accept_s;
  logic [DATA_W-1:0]                  line_s;
  logic [DATA_W-1:0]                  merged_s;

  assign ready_s  = (state_q == ST_IDLE) && !cache.flush_req;
  assign accept_s = cache.req_valid && ready_s;
  assign line_s   = data_q[cache.req_index][cache.req_way];

  // Next-state logic for the idle/sweep controller and the completion pulse.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cache.flush_req) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        cnt_d = cnt_q + IW'(1);
        if (cnt_q == LAST_SET) begin
          state_d      = ST_IDLE;
          flush_done_d = 1'b1;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Controller state, sweep counter and done pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_done_q <= flush_done_d;
    end
  end

  // Byte-enable merge of write data into the currently addressed line.
  always_comb begin
    merged_s = line_s;
    for (int b = 0; b < BE_W; b++) begin
      if (cache.req_be[b]) begin
        merged_s[b*8 +: 8] = cache.req_wdata[b*8 +: 8];
      end else begin
        merged_s[b*8 +: 8] = line_s[b*8 +: 8];
      end
    end
  end

  // Read result registers capture the pre-update line, valid bit and replacement word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q      <= 1'b0;
      rd_data_q       <= '0;
      rd_line_valid_q <= 1'b0;
      rd_lru_q        <= '0;
    end else begin
      rd_valid_q <= accept_s;
      if (accept_s) begin
        rd_data_q       <= line_s;
        rd_line_valid_q <= valid_q[cache.req_index][cache.req_way];
        rd_lru_q        <= lru_q[cache.req_index];
      end
    end
  end

  // Valid bits and replacement words: cleared by reset or sweep, updated by requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      lru_q   <= '0;
    end else if (state_q == ST_FLUSH) begin
      valid_q[cnt_q] <= '0;
      lru_q[cnt_q]   <= '0;
    end else if (accept_s) begin
      if (cache.req_we) begin
        valid_q[cache.req_index][cache.req_way] <= 1'b1;
      end else if (cache.req_inv) begin
        valid_q[cache.req_index][cache.req_way] <= 1'b0;
      end
      if (cache.lru_we) begin
        lru_q[cache.req_index] <= cache.lru_next;
      end
    end
  end

  // Line storage keeps its contents across reset and sweeps.
  always_ff @(posedge clk) begin
    if (accept_s && cache.req_we) begin
      data_q[cache.req_index][cache.req_way] <= merged_s;
    end
  end

  assign cache.req_ready     = ready_s;
  assign cache.rd_valid      = rd_valid_q;
  assign cache.rd_data       = rd_data_q;
  assign cache.rd_line_valid = rd_line_valid_q;
  assign cache.rd_lru        = rd_lru_q;
  assign cache.flush_busy    = (state_q == ST_FLUSH);
  assign cache.flush_done    = flush_done_q;
endmodule

// File: tb/tb_sa_cache_data.sv
// Self-checking bench for sa_cache_data: directed scenarios plus randomized traffic
// compared against an array-based reference model of the cache contents.
module tb_sa_cache_data;
  localparam int NS = 64;
  localparam int NW = 4;
  localparam int DW = 128;
  localparam int LW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  sa_cache_data_if #(.NUM_SETS(NS), .NUM_WAYS(NW), .DATA_W(DW), .LRU_W(LW)) bus ();

  sa_cache_data #(.NUM_SETS(NS), .NUM_WAYS(NW), .DATA_W(DW), .LRU_W(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cache (bus)
  );

  logic [DW-1:0] m_data  [NS][NW];
  bit            m_known [NS][NW];
  bit            m_valid [NS][NW];
  logic [LW-1:0] m_lru   [NS];
  logic [DW-1:0] last_d;
  bit            last_known;
  bit            last_v;
  logic [LW-1:0] last_l;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear_state();
    for (int s = 0; s < NS; s++) begin
      m_lru[s] = '0;
      for (int w = 0; w < NW; w++) m_valid[s][w] = 1'b0;
    end
  endtask

  // One accepted request; req_valid stays high so calls can run back to back.
  task automatic do_req(input int idx, input int way, input bit we, input bit inv,
                        input logic [DW/8-1:0] be, input logic [DW-1:0] wd,
                        input bit lwe, input logic [LW-1:0] ln);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_index = 6'(idx);
    bus.req_way   = 2'(way);
    bus.req_we    = we;
    bus.req_inv   = inv;
    bus.req_be    = be;
    bus.req_wdata = wd;
    bus.lru_we    = lwe;
    bus.lru_next  = ln;
    #1;
    chk("req_ready", DW'(bus.req_ready), DW'(1'b1));
    @(posedge clk);
    #1;
    chk("rd_valid", DW'(bus.rd_valid), DW'(1'b1));
    if (m_known[idx][way]) chk("rd_data", bus.rd_data, m_data[idx][way]);
    chk("rd_line_valid", DW'(bus.rd_line_valid), DW'(m_valid[idx][way]));
    chk("rd_lru", DW'(bus.rd_lru), DW'(m_lru[idx]));
    last_d     = m_data[idx][way];
    last_known = m_known[idx][way];
    last_v     = m_valid[idx][way];
    last_l     = m_lru[idx];
    if (we) begin
      for (int b = 0; b < DW/8; b++)
        if (be[b]) m_data[idx][way][b*8 +: 8] = wd[b*8 +: 8];
      if (&be) m_known[idx][way] = 1'b1;
      m_valid[idx][way] = 1'b1;
    end else if (inv) begin
      m_valid[idx][way] = 1'b0;
    end
    if (lwe) m_lru[idx] = ln;
  endtask

  // One cycle without a request: result flag drops, result fields hold.
  task automatic idle();
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.lru_we    = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_rd_valid", DW'(bus.rd_valid), DW'(1'b0));
    if (last_known) chk("hold_rd_data", bus.rd_data, last_d);
    chk("hold_line_valid", DW'(bus.rd_line_valid), DW'(last_v));
    chk("hold_rd_lru", DW'(bus.rd_lru), DW'(last_l));
  endtask

  task automatic rand_read();
    do_req($urandom_range(0, NS-1), $urandom_range(0, NW-1), 1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    int n;
    int dones;
    bus.req_valid = 1'b0; bus.req_index = '0; bus.req_way = '0; bus.req_we = 1'b0;
    bus.req_inv = 1'b0; bus.req_be = '0; bus.req_wdata = '0; bus.lru_we = 1'b0;
    bus.lru_next = '0; bus.flush_req = 1'b0;
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) begin m_data[s][w] = '0; m_known[s][w] = 1'b0; end
    model_clear_state();

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rd_valid", DW'(bus.rd_valid), DW'(1'b0));
    chk("rst_rd_data", bus.rd_data, '0);
    chk("rst_line_valid", DW'(bus.rd_line_valid), DW'(1'b0));
    chk("rst_rd_lru", DW'(bus.rd_lru), DW'(1'b0));
    chk("rst_busy", DW'(bus.flush_busy), DW'(1'b0));
    chk("rst_done", DW'(bus.flush_done), DW'(1'b0));
    chk("rst_ready", DW'(bus.req_ready), DW'(1'b1));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Fill every line with known data
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++)
        do_req(s, w, 1'b1, 1'b0, '1, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, '0);
    idle();

    // All-ones write then read of index 21 way 3
    do_req(21, 3, 1'b1, 1'b0, '1, '1, 1'b0, '0);
    do_req(21, 3, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    chk("d21_data", bus.rd_data, {DW{1'b1}});
    chk("d21_valid", DW'(bus.rd_line_valid), DW'(1'b1));
    idle();

    // Partial byte write on index 5 way 0
    do_req(5, 0, 1'b1, 1'b0, '1, '0, 1'b0, '0);
    do_req(5, 0, 1'b1, 1'b0, 16'h0001, 128'hAB, 1'b0, '0);
    do_req(5, 0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    chk("d5_data", bus.rd_data, 128'hAB);
    idle();

    // Replacement word update on index 7
    do_req(7, 1, 1'b0, 1'b0, '0, '0, 1'b1, 3'b101);
    chk("d7_lru_pre", DW'(bus.rd_lru), DW'(3'b000));
    idle();
    do_req(7, 2, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    chk("d7_lru_post", DW'(bus.rd_lru), DW'(3'b101));
    idle();

    // Write with no byte enables still validates; invalidate keeps data
    do_req(9, 1, 1'b0, 1'b1, '0, '0, 1'b0, '0);
    do_req(9, 1, 1'b1, 1'b0, '0, '1, 1'b0, '0);
    do_req(9, 1, 1'b0, 1'b1, '1, '1, 1'b0, '0);
    do_req(9, 1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    idle();

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      do_req($urandom_range(0, NS-1), $urandom_range(0, NW-1), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 16'($urandom()),
             {$urandom(), $urandom(), $urandom(), $urandom()},
             1'($urandom_range(0, 1)), 3'($urandom()));
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();

    // Flush started with a competing request
    @(negedge clk);
    bus.flush_req = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_be    = '1;
    bus.req_index = 6'($urandom_range(0, NS-1));
    #1;
    chk("flush_ready", DW'(bus.req_ready), DW'(1'b0));
    @(posedge clk);
    #1;
    chk("flush_no_accept", DW'(bus.rd_valid), DW'(1'b0));
    chk("flush_busy0", DW'(bus.flush_busy), DW'(1'b1));
    @(negedge clk);
    bus.flush_req = 1'b0;
    bus.req_valid = 1'b0;
    n = 1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (!bus.flush_busy) break;
      chk("flush_done_early", DW'(bus.flush_done), DW'(1'b0));
      n++;
      bus.flush_req = (n == 20);
    end
    bus.flush_req = 1'b0;
    chk("flush_cycles", DW'(n), DW'(NS));
    chk("flush_done", DW'(bus.flush_done), DW'(1'b1));
    @(posedge clk);
    #1;
    chk("flush_done_pulse", DW'(bus.flush_done), DW'(1'b0));
    chk("flush_no_restart", DW'(bus.flush_busy), DW'(1'b0));
    model_clear_state();
    for (int i = 0; i < 16; i++) rand_read();
    idle();

    // Asynchronous reset while a read result is presented
    do_req(3, 2, 1'b0, 1'b0, '0, '0, 1'b1, 3'b011);
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    chk("arst_rd_valid", DW'(bus.rd_valid), DW'(1'b0));
    chk("arst_rd_data", bus.rd_data, '0);
    model_clear_state();
    @(negedge clk) rst_n = 1'b1;

    // Asynchronous reset at sweep cycle 10
    @(negedge clk) bus.flush_req = 1'b1;
    @(posedge clk);
    #1 bus.flush_req = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_busy", DW'(bus.flush_busy), DW'(1'b0));
    chk("mid_rd_valid", DW'(bus.rd_valid), DW'(1'b0));
    chk("mid_done", DW'(bus.flush_done), DW'(1'b0));
    @(negedge clk) rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < NS + 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.flush_done) dones++;
    end
    chk("mid_no_done", DW'(dones), DW'(0));
    model_clear_state();
    for (int i = 0; i < 16; i++) rand_read();
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
